// File: rtl/tone_mixer_pkg.sv
// Shared types, defaults and helpers for the tone mixer / PWM audio path.
package tone_mixer_pkg;

    localparam int unsigned N_CH_DEF     = 36;
    localparam int unsigned PWM_BITS_DEF = 6;

    // Encoding 2'd3 is never entered; the scan FSM falls back to S_LOAD from it.
    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_ACC   = 2'd1,
        S_LATCH = 2'd2
    } state_t;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned res;
        res = 0;
        while ((64'd1 << res) < 64'(value)) begin
            res = res + 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/tone_mixer_pwm_pwm_gen.sv
// Free-running PWM: duty is reloaded only at the period boundary so every period is glitch-free.
module pwm_gen
    import tone_mixer_pkg::*;
#(
    parameter int unsigned PWM_BITS = PWM_BITS_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [PWM_BITS-1:0] duty_in,
    output logic                pwm_out
);

    localparam logic [PWM_BITS-1:0] CNT_MAX = '1;

    logic [PWM_BITS-1:0] pwm_cnt;
    logic [PWM_BITS-1:0] duty;

    // duty_in sampled on the last count of a period; a value arriving on that same edge waits a period
    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_cnt <= '0;
            duty    <= '0;
            pwm_out <= 1'b0;
        end else begin
            pwm_cnt <= pwm_cnt + PWM_BITS'(1);
            if (pwm_cnt == CNT_MAX) begin
                duty <= duty_in;
            end
            pwm_out <= (pwm_cnt < duty);
        end
    end

endmodule

// File: rtl/tone_mixer_pwm.sv
// Serially mixes the key-gated tone channels into one sample per frame and drives a single PWM pin.
module tone_mixer_pwm
    import tone_mixer_pkg::*;
#(
    parameter int unsigned N_CH     = N_CH_DEF,
    parameter int unsigned PWM_BITS = PWM_BITS_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_CH-1:0]     keys,
    input  logic [N_CH-1:0]     tone,
    output logic                pwm_out,
    output logic [PWM_BITS-1:0] voices,
    output logic [PWM_BITS-1:0] sample,
    output logic                sample_strobe
);

    localparam int unsigned     CH_W    = (clog2(N_CH) > 0) ? clog2(N_CH) : 1;
    localparam logic [CH_W-1:0] CH_LAST = CH_W'(N_CH - 1);

    // A full chord must stay below a full PWM period so the sum can never overflow.
    if (64'(N_CH) >= (64'd1 << PWM_BITS)) begin : g_width_check
        $error("tone_mixer_pwm: N_CH must be less than 2**PWM_BITS");
    end

    state_t              state;
    logic [N_CH-1:0]     snap;
    logic [N_CH-1:0]     ksnap;
    logic [PWM_BITS-1:0] acc;
    logic [PWM_BITS-1:0] kcnt;
    logic [CH_W-1:0]     ch;

    // Frame: snapshot (1) -> shift-accumulate every channel (N_CH) -> publish (1)
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_LOAD;
            snap          <= '0;
            ksnap         <= '0;
            acc           <= '0;
            kcnt          <= '0;
            ch            <= '0;
            sample        <= '0;
            voices        <= '0;
            sample_strobe <= 1'b0;
        end else begin
            sample_strobe <= 1'b0;
            case (state)
                S_LOAD: begin
                    snap  <= keys & tone;
                    ksnap <= keys;
                    acc   <= '0;
                    kcnt  <= '0;
                    ch    <= '0;
                    state <= S_ACC;
                end
                S_ACC: begin
                    acc   <= acc + PWM_BITS'(snap[0]);
                    kcnt  <= kcnt + PWM_BITS'(ksnap[0]);
                    snap  <= snap >> 1;
                    ksnap <= ksnap >> 1;
                    ch    <= ch + CH_W'(1);
                    if (ch == CH_LAST) begin
                        state <= S_LATCH;
                    end
                end
                S_LATCH: begin
                    sample        <= acc;
                    voices        <= kcnt;
                    sample_strobe <= 1'b1;
                    state         <= S_LOAD;
                end
                default: begin
                    state <= S_LOAD;
                end
            endcase
        end
    end

    pwm_gen #(
        .PWM_BITS(PWM_BITS)
    ) u_pwm_gen (
        .clk     (clk),
        .rst     (rst),
        .duty_in (sample),
        .pwm_out (pwm_out)
    );

endmodule

// File: tb/tb_tone_mixer_pwm.sv
// Directed bench for tone_mixer_pwm: vector table for frame sums plus timed corner-case sequences.
module tb_tone_mixer_pwm;

    localparam int unsigned N = 36;
    localparam int unsigned B = 6;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] keys = '0;
    logic [N-1:0] tone = '0;
    logic         pwm_out;
    logic [B-1:0] voices;
    logic [B-1:0] sample;
    logic         sample_strobe;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [N-1:0] k;
        logic [N-1:0] t;
        int           exp_s;
        int           exp_v;
    } vec_t;

    vec_t vecs[7];

    tone_mixer_pwm #(.N_CH(N), .PWM_BITS(B)) dut (
        .clk           (clk),
        .rst           (rst),
        .keys          (keys),
        .tone          (tone),
        .pwm_out       (pwm_out),
        .voices        (voices),
        .sample        (sample),
        .sample_strobe (sample_strobe)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic step_to(input int target);
        while (cyc < target) step();
    endtask

    task automatic apply_reset(input int n);
        rst = 1'b1;
        repeat (n) step();
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic wait_strobe();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (sample_strobe) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) check("strobe_timeout", 0, 1);
    endtask

    task automatic count_high(input int n, output int highs);
        highs = 0;
        repeat (n) begin
            step();
            highs += int'(pwm_out);
        end
    endtask

    task automatic count_strobes_to(input int target, output int n);
        n = 0;
        while (cyc < target) begin
            step();
            n += int'(sample_strobe);
        end
    endtask

    initial begin
        int h;
        int n;
        logic [N-1:0] b0_35;

        b0_35 = '0;
        b0_35[0] = 1'b1;
        b0_35[35] = 1'b1;
        vecs[0] = '{k: '1,              t: '1,              exp_s: 36, exp_v: 36};
        vecs[1] = '{k: '1,              t: '0,              exp_s: 0,  exp_v: 36};
        vecs[2] = '{k: '0,              t: '1,              exp_s: 0,  exp_v: 0};
        vecs[3] = '{k: 36'h0_0020_0000, t: 36'h0_0020_0000, exp_s: 1,  exp_v: 1};
        vecs[4] = '{k: 36'h0_0000_00FF, t: 36'h0_0000_0F0F, exp_s: 4,  exp_v: 8};
        vecs[5] = '{k: '1,              t: 36'hA_AAAA_AAAA, exp_s: 18, exp_v: 36};
        vecs[6] = '{k: b0_35,           t: b0_35,           exp_s: 2,  exp_v: 2};

        // Reset held with everything pressed and sounding
        keys = '1;
        tone = '1;
        apply_reset(3);
        check("reset_pwm_out", int'(pwm_out), 0);
        check("reset_voices", int'(voices), 0);
        check("reset_sample", int'(sample), 0);
        check("reset_strobe", int'(sample_strobe), 0);

        count_strobes_to(37, n);
        check("first_frame_early_strobe", n, 0);
        step_to(38);
        check("first_strobe_at_38", int'(sample_strobe), 1);
        check("full_chord_sample", int'(sample), 36);
        check("full_chord_voices", int'(voices), 36);
        step();
        check("strobe_one_cycle", int'(sample_strobe), 0);
        step_to(64);
        check("pwm_before_boundary", int'(pwm_out), 0);
        count_high(64, h);
        check("full_chord_pwm_highs", h, 36);

        foreach (vecs[i]) begin
            wait_strobe();
            keys = vecs[i].k;
            tone = vecs[i].t;
            wait_strobe();
            check($sformatf("vec%0d_sample", i), int'(sample), vecs[i].exp_s);
            check($sformatf("vec%0d_voices", i), int'(voices), vecs[i].exp_v);
            repeat (65) step();
            count_high(64, h);
            check($sformatf("vec%0d_pwm_highs", i), h, vecs[i].exp_s);
        end

        // tone[35] only high while the scan runs; the snapshot had it low
        wait_strobe();
        keys = '0;
        keys[21] = 1'b1;
        keys[35] = 1'b1;
        tone = '0;
        tone[21] = 1'b1;
        step();
        tone[35] = 1'b1;
        repeat (36) step();
        tone[35] = 1'b0;
        step();
        check("midscan_strobe", int'(sample_strobe), 1);
        check("midscan_sample", int'(sample), 1);
        check("midscan_voices", int'(voices), 2);

        // Frame 31 publishes on the same edge that ends PWM period 18 (cycle 1215, cnt 63)
        keys = 36'h1F;
        tone = 36'h1F;
        apply_reset(2);
        step_to(1150);
        keys = 36'h3FF;
        tone = 36'h3FF;
        step_to(1178);
        check("race_old_sample", int'(sample), 5);
        step_to(1216);
        check("race_strobe", int'(sample_strobe), 1);
        check("race_new_sample", int'(sample), 10);
        count_high(64, h);
        check("race_period_keeps_old", h, 5);
        count_high(64, h);
        check("race_next_period_new", h, 10);

        // Reset in the middle of the scan, with different inputs afterwards
        keys = '1;
        tone = '1;
        apply_reset(1);
        step_to(18);
        rst = 1'b1;
        keys = 36'hF;
        tone = 36'hF;
        step();
        check("midreset_strobe", int'(sample_strobe), 0);
        check("midreset_sample", int'(sample), 0);
        check("midreset_voices", int'(voices), 0);
        rst = 1'b0;
        cyc = 0;
        count_strobes_to(37, n);
        check("midreset_no_stale_strobe", n, 0);
        step_to(38);
        check("midreset_strobe_at_38", int'(sample_strobe), 1);
        check("midreset_new_sample", int'(sample), 4);
        check("midreset_new_voices", int'(voices), 4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
